// File: rtl/alu_pattern_sequencer.sv
// Applies stored stuck-at vectors to the 2-bit alu, strobes zout after a
// settle window and compares it under mask, keeping pass/fail statistics.
module alu_pattern_sequencer #(
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned PAT_W      = 8,
  parameter int unsigned FAIL_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              pat_valid,
  output logic              pat_ready,
  input  logic [4:0]        pat_pi,
  input  logic [1:0]        pat_xpct,
  input  logic [1:0]        pat_mask,
  input  logic              pat_last,
  output logic [1:0]        alu_ain,
  output logic [1:0]        alu_bin,
  output logic              alu_sel,
  input  logic [1:0]        alu_zout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail_pulse,
  output logic [PAT_W-1:0]  pat_cnt,
  output logic [FAIL_W-1:0] fail_cnt,
  output logic [PAT_W-1:0]  first_fail_idx,
  output logic              first_fail_valid
);

  localparam int unsigned SC_W = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SC_W-1:0] SC_LOAD = SC_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SETTLE,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t            state, state_d;
  logic [SC_W-1:0]   settle_cnt, settle_cnt_d;
  logic [1:0]        xpct_q, xpct_d;
  logic [1:0]        mask_q, mask_d;
  logic              last_q, last_d;
  logic [1:0]        alu_ain_d, alu_bin_d;
  logic              alu_sel_d;
  logic              busy_d, done_d, pass_d, fail_pulse_d;
  logic [PAT_W-1:0]  pat_cnt_d;
  logic [FAIL_W-1:0] fail_cnt_d;
  logic [PAT_W-1:0]  first_fail_idx_d;
  logic              first_fail_valid_d;
  logic [1:0]        mism;

  // Handshake is only offered in FETCH and is withdrawn as soon as abort is seen
  assign pat_ready = (state == S_FETCH) && !abort;

  // Masked mismatch of the strobed alu output against the latched expectation
  assign mism = (alu_zout ^ xpct_q) & mask_q;

  // Next-state and next-output logic
  always_comb begin
    state_d            = state;
    settle_cnt_d       = settle_cnt;
    xpct_d             = xpct_q;
    mask_d             = mask_q;
    last_d             = last_q;
    alu_ain_d          = alu_ain;
    alu_bin_d          = alu_bin;
    alu_sel_d          = alu_sel;
    busy_d             = busy;
    done_d             = done;
    pass_d             = pass;
    fail_pulse_d       = 1'b0;
    pat_cnt_d          = pat_cnt;
    fail_cnt_d         = fail_cnt;
    first_fail_idx_d   = first_fail_idx;
    first_fail_valid_d = first_fail_valid;

    if (abort) begin
      // Drop any vector in flight; counters and alu drives are left as they are
      state_d = S_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d            = S_FETCH;
            busy_d             = 1'b1;
            done_d             = 1'b0;
            pass_d             = 1'b0;
            pat_cnt_d          = '0;
            fail_cnt_d         = '0;
            first_fail_idx_d   = '0;
            first_fail_valid_d = 1'b0;
          end
        end
        S_FETCH: begin
          if (pat_valid) begin
            xpct_d       = pat_xpct;
            mask_d       = pat_mask;
            last_d       = pat_last;
            alu_ain_d    = pat_pi[4:3];
            alu_bin_d    = pat_pi[2:1];
            alu_sel_d    = pat_pi[0];
            settle_cnt_d = SC_LOAD;
            state_d      = S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == '0) begin
            state_d = S_COMPARE;
          end else begin
            settle_cnt_d = settle_cnt - SC_W'(1);
          end
        end
        S_COMPARE: begin
          if (pat_cnt != '1) begin
            pat_cnt_d = pat_cnt + PAT_W'(1);
          end
          if (mism != 2'b00) begin
            fail_pulse_d = 1'b1;
            if (fail_cnt != '1) begin
              fail_cnt_d = fail_cnt + FAIL_W'(1);
            end
            if (!first_fail_valid) begin
              first_fail_idx_d   = pat_cnt;
              first_fail_valid_d = 1'b1;
            end
          end
          if (last_q) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (fail_cnt_d == '0);
          end else begin
            state_d = S_FETCH;
          end
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      settle_cnt       <= '0;
      xpct_q           <= '0;
      mask_q           <= '0;
      last_q           <= 1'b0;
      alu_ain          <= '0;
      alu_bin          <= '0;
      alu_sel          <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      fail_pulse       <= 1'b0;
      pat_cnt          <= '0;
      fail_cnt         <= '0;
      first_fail_idx   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      state            <= state_d;
      settle_cnt       <= settle_cnt_d;
      xpct_q           <= xpct_d;
      mask_q           <= mask_d;
      last_q           <= last_d;
      alu_ain          <= alu_ain_d;
      alu_bin          <= alu_bin_d;
      alu_sel          <= alu_sel_d;
      busy             <= busy_d;
      done             <= done_d;
      pass             <= pass_d;
      fail_pulse       <= fail_pulse_d;
      pat_cnt          <= pat_cnt_d;
      fail_cnt         <= fail_cnt_d;
      first_fail_idx   <= first_fail_idx_d;
      first_fail_valid <= first_fail_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_pattern_sequencer.sv
// Bench for alu_pattern_sequencer: vector tables, a scoreboard of expected
// per-vector fail results, and directed sequences for timing corner cases.
module tb_alu_pattern_sequencer;

  localparam int unsigned S = 4;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, pat_valid, pat_last;
  logic [4:0] pat_pi;
  logic [1:0] pat_xpct, pat_mask;
  logic       pat_ready;
  logic [1:0] alu_ain, alu_bin, alu_zout;
  logic       alu_sel, busy, done, pass, fail_pulse, first_fail_valid;
  logic [7:0] pat_cnt, fail_cnt, first_fail_idx;

  // Second instance with a 2-bit fail counter, fed the same stream in lockstep
  logic       pat_ready2, alu_sel2, busy2, done2, pass2, fail_pulse2, ffv2;
  logic [1:0] alu_ain2, alu_bin2, fail_cnt2;
  logic [7:0] pat_cnt2, ffi2;

  logic       use_force;
  logic [1:0] zout_force;

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_cnt = 0;
  bit sb[$];
  logic [7:0] prev_cnt = '0;

  always #5 clk = ~clk;

  alu_pattern_sequencer #(.SETTLE_CYC(S), .PAT_W(8), .FAIL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .pat_valid(pat_valid), .pat_ready(pat_ready), .pat_pi(pat_pi),
    .pat_xpct(pat_xpct), .pat_mask(pat_mask), .pat_last(pat_last),
    .alu_ain(alu_ain), .alu_bin(alu_bin), .alu_sel(alu_sel), .alu_zout(alu_zout),
    .busy(busy), .done(done), .pass(pass), .fail_pulse(fail_pulse),
    .pat_cnt(pat_cnt), .fail_cnt(fail_cnt), .first_fail_idx(first_fail_idx),
    .first_fail_valid(first_fail_valid)
  );

  alu_pattern_sequencer #(.SETTLE_CYC(S), .PAT_W(8), .FAIL_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .pat_valid(pat_valid), .pat_ready(pat_ready2), .pat_pi(pat_pi),
    .pat_xpct(pat_xpct), .pat_mask(pat_mask), .pat_last(pat_last),
    .alu_ain(alu_ain2), .alu_bin(alu_bin2), .alu_sel(alu_sel2), .alu_zout(alu_zout),
    .busy(busy2), .done(done2), .pass(pass2), .fail_pulse(fail_pulse2),
    .pat_cnt(pat_cnt2), .fail_cnt(fail_cnt2), .first_fail_idx(ffi2),
    .first_fail_valid(ffv2)
  );

  // Reference alu: sel=1 -> and, sel=0 -> or
  function automatic logic [1:0] alu_model(input logic [1:0] a, input logic [1:0] b,
                                           input logic s);
    return s ? (a & b) : (a | b);
  endfunction

  always_comb alu_zout = use_force ? zout_force : alu_model(alu_ain, alu_bin, alu_sel);

  typedef struct {
    logic [4:0] pi;
    logic [1:0] xpct;
    logic [1:0] mask;
    logic       last;
    bit         exp_fail;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Each counted compare pops one expected fail bit and checks fail_pulse
  always @(negedge clk) begin
    if (rst_n) begin
      if (pat_cnt == 8'(prev_cnt + 8'd1)) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_compare");
        end else begin
          check("fail_pulse", 32'(fail_pulse), 32'(sb.pop_front()));
        end
      end else if (fail_pulse) begin
        check("spurious_fail_pulse", 32'(fail_pulse), 0);
      end
      if (fail_pulse) pulse_cnt++;
    end
    prev_cnt = pat_cnt;
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // probe 1: zout correct only at the strobe cycle; probe 2: wrong only there
  task automatic drive_vec(input vec_t v, input bit push, input int probe);
    int n;
    @(negedge clk);
    pat_valid = 1'b1;
    pat_pi    = v.pi;
    pat_xpct  = v.xpct;
    pat_mask  = v.mask;
    pat_last  = v.last;
    n = 0;
    while (!pat_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!pat_ready) begin
      fail_now("accept");
      pat_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (push) sb.push_back(v.exp_fail);
    #1;
    pat_valid = 1'b0;
    check("alu_ain", 32'(alu_ain), 32'(v.pi[4:3]));
    check("alu_bin", 32'(alu_bin), 32'(v.pi[2:1]));
    check("alu_sel", 32'(alu_sel), 32'(v.pi[0]));
    if (probe != 0) begin
      zout_force = (probe == 1) ? ~v.xpct : v.xpct;
      repeat (S) @(posedge clk);
      #1 zout_force = (probe == 1) ? v.xpct : ~v.xpct;
      @(posedge clk);
      #1 zout_force = (probe == 1) ? ~v.xpct : v.xpct;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) fail_now("done");
  endtask

  vec_t golden[8];
  vec_t stuck[8];
  vec_t v;
  logic [4:0] gold_pi[8] = '{5'b11101, 5'b00000, 5'b01100, 5'b11010,
                             5'b10111, 5'b01011, 5'b11110, 5'b00111};
  logic [1:0] st_x[8] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
  logic [1:0] st_m[8] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b11};
  bit         st_f[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    for (int i = 0; i < 8; i++) begin
      golden[i].pi       = gold_pi[i];
      golden[i].xpct     = alu_model(gold_pi[i][4:3], gold_pi[i][2:1], gold_pi[i][0]);
      golden[i].mask     = 2'b11;
      golden[i].last     = (i == 7);
      golden[i].exp_fail = 1'b0;
      stuck[i].pi        = 5'(i * 5 + 3);
      stuck[i].xpct      = st_x[i];
      stuck[i].mask      = st_m[i];
      stuck[i].last      = (i == 7);
      stuck[i].exp_fail  = st_f[i];
    end

    rst_n = 1'b1; start = 1'b0; abort = 1'b0; pat_valid = 1'b0; pat_last = 1'b0;
    pat_pi = '0; pat_xpct = '0; pat_mask = '0; use_force = 1'b0; zout_force = '0;

    // Power-on reset
    #2 rst_n = 1'b0;
    #1;
    check("rst_ctrl", 32'({pat_ready, busy, done, pass, fail_pulse, first_fail_valid,
                           alu_ain, alu_bin, alu_sel}), 0);
    check("rst_cnts", 32'({pat_cnt, fail_cnt, first_fail_idx}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Golden run against the reference alu
    do_start();
    check("busy_after_start", 32'(busy), 1);
    check("pat_ready_fetch", 32'(pat_ready), 1);
    for (int i = 0; i < 8; i++) drive_vec(golden[i], 1'b1, 0);
    wait_done();
    check("gold_done", 32'(done), 1);
    check("gold_pass", 32'(pass), 1);
    check("gold_pat_cnt", 32'(pat_cnt), 8);
    check("gold_fail_cnt", 32'(fail_cnt), 0);
    check("gold_busy", 32'(busy), 0);
    check("gold_ffv", 32'(first_fail_valid), 0);

    // Stuck-at-00 output
    use_force = 1'b1;
    zout_force = 2'b00;
    pulse_cnt = 0;
    do_start();
    for (int i = 0; i < 8; i++) drive_vec(stuck[i], 1'b1, 0);
    wait_done();
    @(negedge clk);
    check("stuck_fail_cnt", 32'(fail_cnt), 3);
    check("stuck_ffi", 32'(first_fail_idx), 0);
    check("stuck_ffv", 32'(first_fail_valid), 1);
    check("stuck_pass", 32'(pass), 0);
    check("stuck_done", 32'(done), 1);
    check("stuck_pulses", 32'(pulse_cnt), 3);
    check("stuck_pat_cnt", 32'(pat_cnt), 8);

    // Mask: bit 0 differs but is don't-care, then compared
    zout_force = 2'b01;
    do_start();
    check("start_clears_done", 32'({done, pass, first_fail_valid}), 0);
    check("start_clears_cnt", 32'(pat_cnt), 0);
    v = '{pi: 5'b10101, xpct: 2'b00, mask: 2'b10, last: 1'b0, exp_fail: 1'b0};
    drive_vec(v, 1'b1, 0);
    v.mask = 2'b11; v.last = 1'b1; v.exp_fail = 1'b1;
    drive_vec(v, 1'b1, 0);
    wait_done();
    check("mask_fail_cnt", 32'(fail_cnt), 1);
    check("mask_ffi", 32'(first_fail_idx), 1);
    check("mask_pass", 32'(pass), 0);

    // Saturation: five failures into a 2-bit counter
    zout_force = 2'b00;
    do_start();
    for (int i = 0; i < 5; i++) begin
      v = '{pi: 5'(i + 9), xpct: 2'b11, mask: 2'b11, last: (i == 4), exp_fail: 1'b1};
      drive_vec(v, 1'b1, 0);
    end
    wait_done();
    check("sat_fail_cnt8", 32'(fail_cnt), 5);
    check("sat_fail_cnt2", 32'(fail_cnt2), 3);
    check("sat_pat_cnt2", 32'(pat_cnt2), 5);
    check("sat_pass2", 32'(pass2), 0);

    // Strobe timing and back-pressure
    do_start();
    v = '{pi: 5'b01010, xpct: 2'b01, mask: 2'b11, last: 1'b0, exp_fail: 1'b0};
    drive_vec(v, 1'b1, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_ready", 32'(pat_ready), 1);
      check("bp_alu_hold", 32'({alu_ain, alu_bin, alu_sel}), 32'(v.pi));
      start = (k == 2);
    end
    start = 1'b0;
    check("start_ignored_busy", 32'({busy, pat_cnt}), 32'({1'b1, 8'd1}));
    v = '{pi: 5'b10011, xpct: 2'b10, mask: 2'b11, last: 1'b1, exp_fail: 1'b1};
    drive_vec(v, 1'b1, 2);
    wait_done();
    check("strobe_fail_cnt", 32'(fail_cnt), 1);
    check("strobe_ffi", 32'(first_fail_idx), 1);

    // Abort during SETTLE drops the vector in flight
    zout_force = 2'b00;
    do_start();
    v = '{pi: 5'b11011, xpct: 2'b00, mask: 2'b11, last: 1'b0, exp_fail: 1'b0};
    drive_vec(v, 1'b1, 0);
    v = '{pi: 5'b01101, xpct: 2'b11, mask: 2'b11, last: 1'b0, exp_fail: 1'b1};
    drive_vec(v, 1'b0, 0);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_flags", 32'({busy, done, pass}), 0);
    check("abort_pat_cnt", 32'(pat_cnt), 1);
    repeat (8) @(negedge clk);
    check("abort_pat_cnt_hold", 32'(pat_cnt), 1);
    check("abort_fail_cnt", 32'(fail_cnt), 0);
    check("abort_alu_hold", 32'({alu_ain, alu_bin, alu_sel}), 32'(5'b01101));

    // Abort in FETCH blocks the handshake in the same cycle
    do_start();
    pat_valid = 1'b1; pat_pi = 5'b10000; pat_xpct = 2'b00; pat_mask = 2'b11;
    abort = 1'b1;
    #1;
    check("abort_ready_low", 32'(pat_ready), 0);
    @(posedge clk);
    #1 abort = 1'b0; pat_valid = 1'b0;
    check("abort_fetch_busy", 32'(busy), 0);
    check("abort_fetch_alu", 32'({alu_ain, alu_bin, alu_sel}), 32'(5'b01101));

    // Reset asserted mid-run
    zout_force = 2'b00;
    do_start();
    v = '{pi: 5'b11111, xpct: 2'b11, mask: 2'b11, last: 1'b0, exp_fail: 1'b1};
    drive_vec(v, 1'b1, 0);
    begin
      int n;
      n = 0;
      while (pat_cnt != 8'd1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (pat_cnt != 8'd1) fail_now("midrun_compare");
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_ctrl", 32'({pat_ready, busy, done, pass, fail_pulse, first_fail_valid,
                              alu_ain, alu_bin, alu_sel}), 0);
    check("midrst_cnts", 32'({pat_cnt, fail_cnt, first_fail_idx}), 0);
    repeat (2) @(negedge clk);
    check("midrst_hold", 32'({fail_pulse, busy, pat_ready}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
